// File: rtl/uart_pkg.sv
// uart_pkg: shared types and baud-rate helpers for the UART receive path.
package uart_pkg;

  // Deframer states, in the order a well-formed frame visits them.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned DEFAULT_CLK_HZ = 48_000_000;
  localparam int unsigned DEFAULT_BAUD   = 115_200;
  localparam int unsigned DATA_BITS      = 8;

  // Clocks per bit, truncated (416 at 48 MHz / 115200).
  function automatic int unsigned bit_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Clocks from the start edge to the middle of the start bit.
  function automatic int unsigned half_div(input int unsigned clk_hz, input int unsigned baud);
    return bit_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous first-word-fall-through FIFO for received bytes.
// The head byte is held in a register so head_data is clean from reset and only
// moves on clock edges. A push into a full FIFO is dropped and flagged, unless a
// pop happens in the same cycle, which frees the slot the push needs.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_n;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign head_valid = !empty;
  assign head_data  = head_q;
  assign rd_next    = rd_ptr + AW'(1);

  // Pop only a real entry; a push into a full FIFO survives only alongside a pop.
  assign pop     = head_valid && pop_ready;
  assign push_ok = push_valid && (!full || pop);
  assign drop    = push_valid && full && !pop;

  // Storage array: write-only on accepted pushes.
  // NOTE: the storage array has no reset; nothing reads a slot before it is written,
  // and leaving it out keeps the array mappable onto plain RAM/flop arrays.
  always_ff @(posedge clk_48mhz) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pick the head value the next cycle will present.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which is what would otherwise infer a latch.
    head_n = head_q;
    if (empty) begin
      if (push_ok) begin
        head_n = push_data;
      end
    end else if (pop) begin
      if (count == ONE_CNT) begin
        // Last entry leaves; a simultaneous push becomes the new head, otherwise
        // the stale head is simply held.
        if (push_ok) begin
          head_n = push_data;
        end
      end else begin
        head_n = mem[rd_next];
      end
    end
  end

  // Pointers, occupancy, head register and overrun pulse.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      head_q  <= '0;
      overrun <= 1'b0;
    end else begin
      head_q  <= head_n;
      overrun <= drop;
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receiver. Synchronises the Rx pin, qualifies the
// start bit at mid-bit, samples eight data bits LSB first at mid-bit, checks the
// stop bit and queues good bytes in a FWFT FIFO drained by a valid/ready port.
// Reset asserts asynchronously; its release is expected to be synchronised
// to clk_48mhz upstream.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEFAULT_CLK_HZ,
  parameter int unsigned BAUD       = DEFAULT_BAUD,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned BIT_DIV  = bit_div(CLK_HZ, BAUD);
  localparam int unsigned HALF_DIV = half_div(CLK_HZ, BAUD);
  localparam int unsigned TW       = $clog2(BIT_DIV);

  localparam logic [TW-1:0] BIT_RELOAD  = TW'(BIT_DIV - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF_DIV - 1);
  localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

  // Synchroniser
  logic rx_meta;
  logic rx_s;

  // Bit timer
  logic [TW-1:0] bit_cnt;
  logic          tick;
  logic          load_half;
  logic          load_bit;

  // Deframer
  rx_state_t  state;
  rx_state_t  state_n;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       shift_en;
  logic       bit_clr;
  logic       push;
  logic       ferr_set;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (bit_cnt == '0);

  // Bit timer: the FSM reloads it on phase changes, otherwise it free-runs one bit period per tick.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
    end else if (load_half) begin
      bit_cnt <= HALF_RELOAD;
    end else if (load_bit || tick) begin
      bit_cnt <= BIT_RELOAD;
    end else begin
      bit_cnt <= bit_cnt - TW'(1);
    end
  end

  // Deframer state register.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and control strobes for the deframer.
  always_comb begin
    state_n   = state;
    load_half = 1'b0;
    load_bit  = 1'b0;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    push      = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          load_half = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            // Line back high at mid start bit: a glitch, silently ignored.
            state_n = IDLE;
          end else begin
            load_bit = 1'b1;
            bit_clr  = 1'b1;
            state_n  = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_BIT) begin
            load_bit = 1'b1;
            state_n  = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold here until the line idles so a long break flags only once.
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Data shift register (LSB arrives first, so shift right) and bit index.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (bit_clr) begin
      bit_idx <= '0;
    end else if (shift_en) begin
      shreg   <= {rx_s, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Registered one-cycle frame error pulse.
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= ferr_set;
    end
  end

  assign busy = (state != IDLE);

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_48mhz  (clk_48mhz),
    .reset      (reset),
    .push_valid (push),
    .push_data  (shreg),
    .pop_ready  (rx_ready),
    .head_data  (rx_data),
    .head_valid (rx_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: drives serial frames onto rx_in and checks the byte stream
// through a scoreboard queue. A line-level reference decides, per frame, whether
// a byte should appear, raise frame_err, or be dropped as an overrun.
module tb_uart_rx_deframer;

  localparam int CLK_HZ    = 48_000_000;
  localparam int BAUD      = 115_200;
  localparam int BIT_DIV   = CLK_HZ / BAUD;
  localparam int HALF_DIV  = BIT_DIV / 2;
  localparam int DEPTH     = 4;
  localparam int FRAME_CYC = 10 * BIT_DIV;
  // Start edge to rx_valid: 2 sync + 1 FSM clocks, half a bit to mid start,
  // nine more bits to mid stop, then one clock for the push to show.
  localparam int VALID_LAT = 3 + HALF_DIV + 9 * BIT_DIV;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       rx_in     = 1'b1;
  logic       rx_ready  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks     = 0;
  int n_fail       = 0;
  int n_popped     = 0;
  int n_exp_pushed = 0;
  int ferr_seen    = 0;
  int ovr_seen     = 0;
  int exp_ferr     = 0;
  int exp_ovr      = 0;

  logic [7:0] exp_q[$];

  always #10 clk_48mhz = ~clk_48mhz;

  uart_rx_deframer #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every handshake pops the scoreboard; flag pulses are tallied.
  initial begin
    forever begin
      @(negedge clk_48mhz);
      if (!reset) begin
        if (rx_valid && rx_ready) begin
          check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
          end
          n_popped++;
        end
        if (frame_err) ferr_seen++;
        if (overrun)   ovr_seen++;
      end
    end
  end

  // Reference: what a frame should produce, given FIFO occupancy and
  // whether the consumer pops in the same cycle the byte lands.
  task automatic expect_frame(input logic [7:0] b, input bit stop_ok, input bit pop_at_stop);
    if (!stop_ok) begin
      exp_ferr++;
    end else if ((n_exp_pushed - n_popped) >= DEPTH && !pop_at_stop) begin
      exp_ovr++;
    end else begin
      exp_q.push_back(b);
      n_exp_pushed++;
    end
  endtask

  // Drive one 8N1 frame (start, LSB-first data, stop). Optionally pulses
  // rx_ready on one cycle, randomises rx_ready, or stops early.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int pulse_at,
                            input bit rand_rdy, input int abort_at, output int first_valid);
    logic [9:0] frame;
    frame       = {stop_bit, b, 1'b0};
    first_valid = -1;
    @(posedge clk_48mhz);
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (c == abort_at) break;
      #1;
      rx_in = frame[c / BIT_DIV];
      if (pulse_at >= 0) rx_ready = (c == pulse_at);
      else if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
      @(negedge clk_48mhz);
      if (rx_valid && first_valid < 0) first_valid = c;
      @(posedge clk_48mhz);
    end
    #1;
    rx_in = 1'b1;
    if (pulse_at >= 0) rx_ready = 1'b0;
    if (rand_rdy) rx_ready = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rand_rdy);
    int fv;
    expect_frame(b, 1'b1, 1'b0);
    send_frame(b, 1'b1, -1, rand_rdy, -1, fv);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk_48mhz);
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  // Short low pulse on an idle line; START must give up exactly at mid-bit.
  task automatic glitch(input int len);
    @(posedge clk_48mhz);
    for (int c = 0; c < 260; c++) begin
      #1;
      rx_in = (c < len) ? 1'b0 : 1'b1;
      @(negedge clk_48mhz);
      if (c == 20)  check("glitch_busy_early", 32'(busy), 32'd1);
      if (c == 210) check("glitch_busy_last", 32'(busy), 32'd1);
      if (c == 211) check("glitch_busy_done", 32'(busy), 32'd0);
      @(posedge clk_48mhz);
    end
    #1;
    rx_in = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk_48mhz);
    check({tag, "_rx_data"},   32'(rx_data),   32'd0);
    check({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_overrun"},   32'(overrun),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int         fv;
    logic [7:0] rb;

    // Reset state.
    reset = 1'b1;
    idle(5);
    check_reset_outputs("reset");
    @(posedge clk_48mhz);
    #1;
    reset = 1'b0;
    idle(20);

    // Back-to-back bytes with the consumer always ready, then random bytes
    // with a randomly toggling consumer.
    rx_ready = 1'b1;
    send_byte(8'h55, 1'b0);
    send_byte(8'hA3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb, 1'b1);
    end
    wait_drain(2000);
    check("t1_frame_err", 32'(ferr_seen), 32'(exp_ferr));
    check("t1_overrun",   32'(ovr_seen),  32'(exp_ovr));

    // Glitch on the idle line.
    glitch(int'($urandom_range(20, 180)));
    idle(50);
    check("t2_rx_valid",  32'(rx_valid),  32'd0);
    check("t2_frame_err", 32'(ferr_seen), 32'(exp_ferr));

    // Bad stop bit, then a long break: one frame_err each.
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, -1, 1'b0, -1, fv);
    idle(20);
    check("t3_frame_err", 32'(ferr_seen), 32'(exp_ferr));
    expect_frame(8'h00, 1'b0, 1'b0);
    @(posedge clk_48mhz);
    #1;
    rx_in = 1'b0;
    idle(4500);
    rx_in = 1'b1;
    idle(20);
    check("t3_break_frame_err", 32'(ferr_seen), 32'(exp_ferr));
    check("t3_rx_valid",        32'(rx_valid),  32'd0);
    check("t3_busy",            32'(busy),      32'd0);

    // Consumer stalled: fill the FIFO, overflow once, then pop exactly in the
    // stop-tick cycle of the next byte so that push is accepted.
    rx_ready = 1'b0;
    expect_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, -1, 1'b0, -1, fv);
    check("t4_valid_latency", 32'(fv), 32'(VALID_LAT));
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    @(negedge clk_48mhz);
    check("t4_full_valid", 32'(rx_valid), 32'd1);
    check("t4_full_head",  32'(rx_data),  32'h01);
    send_byte(8'h05, 1'b0);
    idle(5);
    check("t4_overrun", 32'(ovr_seen), 32'(exp_ovr));
    expect_frame(8'h06, 1'b1, 1'b1);
    send_frame(8'h06, 1'b1, VALID_LAT - 1, 1'b0, -1, fv);
    idle(5);
    check("t5_no_overrun", 32'(ovr_seen), 32'(exp_ovr));
    rx_ready = 1'b1;
    wait_drain(100);

    // Reset in the middle of a frame with two bytes queued.
    rx_ready = 1'b0;
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    send_frame(8'h7E, 1'b1, -1, 1'b0, 4 * BIT_DIV, fv);
    @(negedge clk_48mhz);
    check("t6_busy_before",  32'(busy),     32'd1);
    check("t6_valid_before", 32'(rx_valid), 32'd1);
    @(posedge clk_48mhz);
    #1;
    reset = 1'b1;
    exp_q.delete();
    n_exp_pushed = n_popped;
    check_reset_outputs("t6_reset");
    idle(3);
    reset = 1'b0;
    idle(50);
    check("t6_valid_after", 32'(rx_valid), 32'd0);
    check("t6_busy_after",  32'(busy),     32'd0);
    rx_ready = 1'b1;
    expect_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, -1, 1'b0, -1, fv);
    check("t6_valid_latency", 32'(fv), 32'(VALID_LAT));
    wait_drain(100);

    idle(10);
    check("final_frame_err", 32'(ferr_seen), 32'(exp_ferr));
    check("final_overrun",   32'(ovr_seen),  32'(exp_ovr));
    check("final_queue",     32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
